uart_stream: RTL and testbench

UART_STREAM -- requirements
Module: uart_stream

---
 rtl/uart_stream_if.sv | 30 +++
 rtl/uart_stream.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_stream.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_if.sv
// rtl/uart_stream_if.sv - stream-side handshake bundle for uart_stream
interface uart_stream_if #(
    parameter int DATA_BITS     = 8,
    parameter int TX_FIFO_DEPTH = 16
);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [CW-1:0]        tx_count;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    // The UART core sits on the slave side: it accepts TX words, reports RX words
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_count, tx_busy,
        output rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_count, tx_busy,
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_stream.sv
// rtl/uart_stream.sv - UART with TX FIFO and independent TX/RX state machines
module uart_stream #(
    parameter int DELAY_FRAMES  = 234,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         uart_rx,
    output logic         uart_tx,
    uart_stream_if.slave bus
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(STOP_BITS * DELAY_FRAMES + 1);

    localparam logic [TW-1:0] BIT_LAST   = TW'(DELAY_FRAMES - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(DELAY_FRAMES / 2 - 1);
    localparam logic [TW-1:0] STOP_LAST  = TW'(STOP_BITS * DELAY_FRAMES - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(TX_FIFO_DEPTH);
    localparam logic          HAS_PARITY = (PARITY != 0);
    localparam logic          ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [TX_FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;

    logic                 w_tx_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_parity;

    // ---------------- TX FSM ----------------
    tx_state_t            r_tx_state;
    logic [TW-1:0]        r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_uart_tx;
    logic                 r_tx_busy;

    // ---------------- RX ----------------
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx;
    rx_state_t            r_rx_state;
    logic [TW-1:0]        r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par;
    logic                 r_rx_hold;
    logic                 r_rx_valid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;

    assign w_tx_ready    = !rst && (r_count < FIFO_FULL);
    assign w_push        = bus.tx_valid && w_tx_ready;
    // A word leaves the FIFO either from idle or exactly at the end of STOP,
    // so back-to-back frames follow each other with no idle gap.
    assign w_pop         = (r_count != '0) &&
                           ((r_tx_state == TX_IDLE) ||
                            ((r_tx_state == TX_STOP) && (r_tx_cnt == STOP_LAST)));
    assign w_head        = r_mem[r_rptr];
    assign w_head_parity = (^w_head) ^ ODD_PARITY;
    assign w_rx          = r_sync2;

    // FIFO storage: written on every accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.tx_data;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // TX FSM: line level is registered from the state, so it trails the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_uart_tx  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_uart_tx <= 1'b1;
                    r_tx_busy <= 1'b0;
                    r_tx_cnt  <= '0;
                    if (w_pop) begin
                        r_tx_shift <= w_head;
                        r_tx_par   <= w_head_parity;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    r_uart_tx <= 1'b0;
                    r_tx_busy <= 1'b1;
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TW'(1);
                    end
                end
                TX_DATA: begin
                    r_uart_tx <= r_tx_shift[0];
                    r_tx_busy <= 1'b1;
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= r_tx_shift >> 1;
                        if (r_tx_bit == DATA_LAST) begin
                            r_tx_state <= HAS_PARITY ? TX_PARITY : TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 4'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TW'(1);
                    end
                end
                TX_PARITY: begin
                    r_uart_tx <= r_tx_par;
                    r_tx_busy <= 1'b1;
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TW'(1);
                    end
                end
                TX_STOP: begin
                    r_uart_tx <= 1'b1;
                    r_tx_busy <= 1'b1;
                    if (r_tx_cnt == STOP_LAST) begin
                        r_tx_cnt <= '0;
                        if (w_pop) begin
                            r_tx_shift <= w_head;
                            r_tx_par   <= w_head_parity;
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TW'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous serial input, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // RX FSM: sample at bit midpoints, report word and flags at the first stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_hold  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt  <= '0;
                    r_rx_hold <= 1'b0;
                    if (!w_rx) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        // A start bit that has gone high by its midpoint was a glitch
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == DATA_LAST) begin
                            r_rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 4'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + TW'(1);
                    end
                end
                RX_PARITY: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= w_rx;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_hold) begin
                        // Break / framing error: wait for the line to recover
                        if (w_rx) begin
                            r_rx_hold  <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                        r_rx_perr  <= HAS_PARITY && (((^r_rx_shift) ^ ODD_PARITY) != r_rx_par);
                        r_rx_ferr  <= !w_rx;
                        if (w_rx) r_rx_state <= RX_IDLE;
                        else      r_rx_hold  <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + TW'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign uart_tx           = r_uart_tx;
    assign bus.tx_ready      = w_tx_ready;
    assign bus.tx_count      = r_count;
    assign bus.tx_busy       = r_tx_busy;
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_rx_perr;
    assign bus.rx_frame_err  = r_rx_ferr;
endmodule

// File: tb/tb_uart_stream.sv
// tb/tb_uart_stream.sv - randomized self-checking bench for uart_stream
module tb_uart_stream;
    localparam int DF    = 8;
    localparam int FRAME = 10 * DF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic tx0;
    logic tx1;
    logic tx2;

    int n_checks = 0;
    int n_errors = 0;

    int          v0, v1, v2;
    logic [7:0]  d0, d1, d2;
    logic        pe0, pe1, pe2, fe0, fe1, fe2;
    logic [7:0]  tw [5];

    always #5 clk = ~clk;

    uart_stream_if #(.DATA_BITS(8), .TX_FIFO_DEPTH(4)) if0 ();
    uart_stream_if #(.DATA_BITS(8), .TX_FIFO_DEPTH(4)) if1 ();
    uart_stream_if #(.DATA_BITS(8), .TX_FIFO_DEPTH(4)) if2 ();

    uart_stream #(.DELAY_FRAMES(DF), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TX_FIFO_DEPTH(4))
        dut0 (.clk(clk), .rst(rst), .uart_rx(rx0), .uart_tx(tx0), .bus(if0));
    uart_stream #(.DELAY_FRAMES(DF), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .TX_FIFO_DEPTH(4))
        dut1 (.clk(clk), .rst(rst), .uart_rx(rx1), .uart_tx(tx1), .bus(if1));
    uart_stream #(.DELAY_FRAMES(DF), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .TX_FIFO_DEPTH(4))
        dut2 (.clk(clk), .rst(rst), .uart_rx(tx2), .uart_tx(tx2), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; records every rx_valid pulse with its word and flags
    task automatic tick();
        @(posedge clk);
        #1;
        if (if0.rx_valid) begin v0++; d0 = if0.rx_data; pe0 = if0.rx_parity_err; fe0 = if0.rx_frame_err; end
        if (if1.rx_valid) begin v1++; d1 = if1.rx_data; pe1 = if1.rx_parity_err; fe1 = if1.rx_frame_err; end
        if (if2.rx_valid) begin v2++; d2 = if2.rx_data; pe2 = if2.rx_parity_err; fe2 = if2.rx_frame_err; end
    endtask

    // Expected line c edges after the first push: frames start 2 edges after it, back to back
    function automatic logic exp_line(input int c, input int n);
        int t, k, b;
        if (c < 2 || c - 2 >= n * FRAME) return 1'b1;
        t = c - 2;
        k = t / FRAME;
        b = (t % FRAME) / DF;
        if (b == 0) return 1'b0;
        if (b <= 8) return tw[k][b-1];
        return 1'b1;
    endfunction

    // Occupancy: accepted pushes minus words taken one edge before each frame's start bit
    function automatic int exp_count(input int c, input int n);
        int pushed, popped;
        pushed = (c + 1 < n) ? c + 1 : n;
        popped = 0;
        for (int k = 0; k < n; k++) if (1 + FRAME * k <= c) popped++;
        return pushed - popped;
    endfunction

    task automatic tx_stream(input int n, input bit junk);
        int ec;
        for (int c = 0; c < n * FRAME + 12; c++) begin
            if (c < n) begin
                chk("tx_accept", 32'(if0.tx_ready), 1);
                if0.tx_valid = 1'b1;
                if0.tx_data  = tw[c];
            end else if (junk && c < n + 12) begin
                if0.tx_valid = 1'b1;
                if0.tx_data  = 8'hFF;
            end else begin
                if0.tx_valid = 1'b0;
            end
            tick();
            ec = exp_count(c, n);
            chk("tx_count", 32'(if0.tx_count), ec);
            chk("tx_ready", 32'(if0.tx_ready), 32'(ec < 4));
            chk("uart_tx", 32'(tx0), 32'(exp_line(c, n)));
            chk("tx_busy", 32'(if0.tx_busy), 32'(c >= 2 && c < 2 + n * FRAME));
        end
        if0.tx_valid = 1'b0;
    endtask

    task automatic rx_drive(input int sel, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx0 = b; else rx1 = b;
            tick();
        end
    endtask

    task automatic rx_frame(input int sel, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit);
        rx_drive(sel, 1'b0, DF);
        for (int i = 0; i < 8; i++) rx_drive(sel, d[i], DF);
        if (with_par) rx_drive(sel, par_bit, DF);
        rx_drive(sel, stop_bit, DF);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] d;
        v0 = 0; v1 = 0; v2 = 0;
        if0.tx_valid = 1'b0; if0.tx_data = '0;
        if1.tx_valid = 1'b0; if1.tx_data = '0;
        if2.tx_valid = 1'b0; if2.tx_data = '0;

        repeat (3) tick();
        chk("rst_uart_tx", 32'(tx0), 1);
        chk("rst_uart_tx1", 32'(tx1), 1);
        chk("rst_uart_tx2", 32'(tx2), 1);
        chk("rst_tx_ready", 32'(if0.tx_ready), 0);
        chk("rst_tx_count", 32'(if0.tx_count), 0);
        chk("rst_tx_busy", 32'(if0.tx_busy), 0);
        chk("rst_rx_valid", 32'(if0.rx_valid), 0);
        chk("rst_rx_data", 32'(if0.rx_data), 0);
        chk("rst_rx_perr", 32'(if1.rx_parity_err), 0);
        chk("rst_rx_ferr", 32'(if1.rx_frame_err), 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("ready_after_rst", 32'(if0.tx_ready), 1);

        // Single 0xA5 frame, then a five-word burst with pushes attempted while full
        tw[0] = 8'hA5;
        tx_stream(1, 1'b0);
        for (int i = 0; i < 5; i++) tw[i] = 8'($urandom_range(0, 255));
        tx_stream(5, 1'b1);

        // Loopback with even parity: 0x07 first, then random words
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? 8'h07 : 8'($urandom_range(0, 255));
            v2 = 0;
            if2.tx_valid = 1'b1;
            if2.tx_data  = w;
            tick();
            if2.tx_valid = 1'b0;
            for (int c = 1; c < 120; c++) begin
                tick();
                if (c == 78) chk("lb_parity_bit", 32'(tx2), 32'(^w));
            end
            chk("lb_valid_count", v2, 1);
            chk("lb_data", 32'(d2), 32'(w));
            chk("lb_perr", 32'(pe2), 0);
            chk("lb_ferr", 32'(fe2), 0);
        end

        // Framing error followed by a long break, then a clean frame
        v0 = 0;
        d = 8'($urandom_range(0, 255));
        rx_frame(0, d, 1'b0, 1'b0, 1'b0);
        rx_drive(0, 1'b0, 50);
        rx_drive(0, 1'b1, 30);
        chk("brk_valid_count", v0, 1);
        chk("brk_data", 32'(d0), 32'(d));
        chk("brk_ferr", 32'(fe0), 1);
        chk("brk_perr", 32'(pe0), 0);
        d = 8'($urandom_range(0, 255));
        rx_frame(0, d, 1'b0, 1'b0, 1'b1);
        rx_drive(0, 1'b1, 30);
        chk("rx_valid_count", v0, 2);
        chk("rx_data", 32'(d0), 32'(d));
        chk("rx_ferr", 32'(fe0), 0);
        chk("rx_perr", 32'(pe0), 0);
        chk("rx_data_held", 32'(if0.rx_data), 32'(d));

        // Short glitch, then odd-parity frames with wrong and right parity
        v1 = 0;
        rx_drive(1, 1'b0, 3);
        rx_drive(1, 1'b1, 40);
        chk("glitch_no_valid", v1, 0);
        d = 8'($urandom_range(0, 255));
        rx_frame(1, d, 1'b1, ^d, 1'b1);
        rx_drive(1, 1'b1, 30);
        chk("bad_par_count", v1, 1);
        chk("bad_par_data", 32'(d1), 32'(d));
        chk("bad_par_perr", 32'(pe1), 1);
        chk("bad_par_ferr", 32'(fe1), 0);
        d = 8'($urandom_range(0, 255));
        rx_frame(1, d, 1'b1, ~^d, 1'b1);
        rx_drive(1, 1'b1, 30);
        chk("good_par_count", v1, 2);
        chk("good_par_data", 32'(d1), 32'(d));
        chk("good_par_perr", 32'(pe1), 0);

        // Reset mid-DATA with two words still queued
        for (int c = 0; c < 3; c++) begin
            if0.tx_valid = 1'b1;
            if0.tx_data  = 8'($urandom_range(0, 255));
            tick();
        end
        if0.tx_valid = 1'b0;
        repeat (20) tick();
        chk("pre_rst_count", 32'(if0.tx_count), 2);
        chk("pre_rst_busy", 32'(if0.tx_busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_uart_tx", 32'(tx0), 1);
        chk("abort_count", 32'(if0.tx_count), 0);
        chk("abort_busy", 32'(if0.tx_busy), 0);
        chk("abort_ready", 32'(if0.tx_ready), 0);
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            chk("post_rst_uart_tx", 32'(tx0), 1);
            chk("post_rst_busy", 32'(if0.tx_busy), 0);
        end
        chk("post_rst_count", 32'(if0.tx_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
